// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch (I) and data access (D).
// D has priority; a starvation counter forces an I grant, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
   parameter int unsigned WORD       = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_req,
   input  logic [WORD-1:0] i_addr,
   output logic [WORD-1:0] i_rdata,
   output logic            i_done,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [WORD-1:0] d_addr,
   input  logic [WORD-1:0] d_wdata,
   output logic [WORD-1:0] d_rdata,
   output logic            d_done,
   output logic            mem_req,
   output logic            mem_we,
   output logic [WORD-1:0] mem_addr,
   output logic [WORD-1:0] mem_wdata,
   input  logic [WORD-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            timeout_err,
   output logic            busy
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
   localparam logic [TW-1:0] WdogLast  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StDone} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [TW-1:0]   wdog_q, wdog_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [WORD-1:0] mem_addr_q, mem_addr_d;
   logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
   logic [WORD-1:0] i_rdata_q, i_rdata_d;
   logic [WORD-1:0] d_rdata_q, d_rdata_d;
   logic            i_done_q, i_done_d;
   logic            d_done_q, d_done_d;
   logic            terr_q, terr_d;
   logic            busy_q, busy_d;
   logic            grant_i;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      wdog_d      = wdog_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      terr_d      = 1'b0;
      grant_i     = i_req && (!d_req || (starve_q == StarveMax));

      unique case (state_q)
         StIdle: begin
            wdog_d = '0;
            if (grant_i) begin
               state_d     = StIBusy;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
               starve_d    = '0;
            end else if (d_req) begin
               state_d     = StDBusy;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               if (i_req && (starve_q != StarveMax)) starve_d = starve_q + 1'b1;
            end
         end
         StIBusy, StDBusy: begin
            // Completion and watchdog abort share one path; only rdata and timeout_err differ.
            if (mem_ready || (wdog_q == WdogLast)) begin
               state_d   = StDone;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               wdog_d    = '0;
               terr_d    = !mem_ready;
               if (state_q == StIBusy) begin
                  i_done_d  = 1'b1;
                  i_rdata_d = mem_ready ? mem_rdata : '0;
               end else begin
                  d_done_d  = 1'b1;
                  d_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
               end
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         starve_q    <= '0;
         wdog_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         terr_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         wdog_q      <= wdog_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         terr_q      <= terr_d;
         busy_q      <= busy_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign i_done      = i_done_q;
   assign d_done      = d_done_q;
   assign timeout_err = terr_q;
   assign busy        = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-ported memory between the instruction-fetch requester (I, read-only) and the data-access requester (D, read/write).
- Sits between the fetch/memory stages of the processor and the shared memory; the stages stall on their req until done.
- Data port has priority; a starvation counter guarantees fetch progress.
- Watchdog aborts memory transactions that never complete.

Parameters:
- WORD, 32, data/address width.
- STARVE_MAX, 4, consecutive D grants allowed while i_req is pending before I is forced.
- TIMEOUT, 16, cycles in a BUSY state without mem_ready before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_done.
- i_addr  in  WORD  fetch address.
- i_rdata  out  WORD  fetch data, valid while i_done=1.
- i_done  out  1  one-cycle completion pulse to I.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_done.
- d_we  in  1  1=write, 0=read.
- d_addr  in  WORD  data address.
- d_wdata  in  WORD  write data.
- d_rdata  out  WORD  read data, valid while d_done=1 (undefined for writes; drives 0).
- d_done  out  1  one-cycle completion pulse to D.
- mem_req  out  1  request to shared memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  WORD  memory address.
- mem_wdata  out  WORD  memory write data.
- mem_rdata  in  WORD  memory read data, valid with mem_ready.
- mem_ready  in  1  memory accepts/completes the access in this cycle.
- timeout_err  out  1  one-cycle pulse coincident with the aborting done.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-transaction): state=IDLE; all outputs 0; starve counter and watchdog counter 0. The in-flight access is dropped with no done.
- FSM states and transitions:
  - IDLE: choose the grantee (rules below). On the next edge go to I_BUSY or D_BUSY, latch addr/we/wdata onto mem_*, set mem_req=1. With no request, stay in IDLE.
  - Grant rule: if only one req, grant it. If both, grant D unless starve_cnt==STARVE_MAX, in which case grant I.
  - starve_cnt: +1 on each D grant while i_req=1, saturating at STARVE_MAX; cleared on any I grant.
  - I_BUSY / D_BUSY: hold mem_* stable. On an edge where mem_ready=1: clear mem_req/mem_we, register mem_rdata into the owner's rdata (0 for writes), assert the owner's done for one cycle, go to DONE.
  - I_BUSY / D_BUSY watchdog: counts cycles in the state. When it reaches TIMEOUT with no mem_ready, abort exactly as on completion, with rdata=0 and timeout_err=1.
  - DONE: done/timeout_err high for this cycle only; requests are ignored. Next edge goes to IDLE with done cleared.
- Latency:
  - req sampled at edge 0 → mem_req high after edge 1.
  - mem_ready in the first mem_req cycle → done high after edge 2.
  - Minimum spacing between grants is 3 cycles (BUSY, DONE, IDLE).
- Requester protocol: deassert req, or present a new request, in the cycle after done. A req held through DONE is treated as a new request.
- mem_ready while in IDLE/DONE is ignored.
- Requests arriving during BUSY wait; they are not queued beyond the req level.
- mem_we is never 1 for an I grant.

Test Plan:
- Single D write: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF, mem_ready=1 immediately → mem_req/mem_we high one cycle with addr 0x10; d_done pulses 1 cycle; d_rdata=0; i_done stays 0.
- Single I read with 3-cycle memory wait: i_addr=0x400000, mem_rdata=0x2108000A on the 3rd mem_req cycle → i_done after edge 4 with i_rdata=0x2108000A.
- Both requesting continuously, mem_ready always 1, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I…; starve_cnt cleared after each I.
- mem_ready held 0, TIMEOUT=16 → after 16 BUSY cycles the owner's done and timeout_err pulse together with rdata=0; FSM returns to IDLE and serves the next req.
- rst_n asserted low in the middle of D_BUSY → all outputs 0 immediately (async); after release with i_req=1, an I grant occurs with no stale d_done.
